// File: rtl/pw_psum_accumulator_pkg.sv
// Shared widths, FSM encoding and saturation helpers for the pointwise-conv
// partial-sum combiner.
package pw_psum_accumulator_pkg;

   localparam int DATA_WIDTH_DEF  = 8;
   localparam int PE_NUM_DEF      = 8;
   localparam int PSUM_WIDTH_DEF  = 20;
   localparam int BIAS_WIDTH_DEF  = 16;
   localparam int SHIFT_WIDTH_DEF = 5;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_WAIT_HI = 1'b1
   } state_e;

   function automatic int acc_width(input int psum_w, input int bias_w);
      return ((psum_w > bias_w) ? psum_w : bias_w) + 2;
   endfunction

   function automatic int sat_hi(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

   function automatic int sat_lo(input int w);
      return -(1 << (w - 1));
   endfunction

endpackage

// File: rtl/pw_psum_accumulator_if.sv
// Slice input / pixel output bundle between the PW MAC array, this combiner
// and the feature writer.
interface pw_psum_accumulator_if #(
   parameter int DATA_WIDTH  = pw_psum_accumulator_pkg::DATA_WIDTH_DEF,
   parameter int PE_NUM      = pw_psum_accumulator_pkg::PE_NUM_DEF,
   parameter int PSUM_WIDTH  = pw_psum_accumulator_pkg::PSUM_WIDTH_DEF,
   parameter int BIAS_WIDTH  = pw_psum_accumulator_pkg::BIAS_WIDTH_DEF,
   parameter int SHIFT_WIDTH = pw_psum_accumulator_pkg::SHIFT_WIDTH_DEF
);
   logic                         psum_valid;
   logic                         psum_phase;
   logic [PE_NUM*PSUM_WIDTH-1:0] psum_in;
   logic [PE_NUM*BIAS_WIDTH-1:0] bias_in;
   logic [SHIFT_WIDTH-1:0]       shift_in;
   logic                         relu_en;
   logic                         out_valid;
   logic [PE_NUM*DATA_WIDTH-1:0] data_out;
   logic                         phase_err;

   modport slave (
      input  psum_valid, psum_phase, psum_in, bias_in, shift_in, relu_en,
      output out_valid, data_out, phase_err
   );

   modport master (
      output psum_valid, psum_phase, psum_in, bias_in, shift_in, relu_en,
      input  out_valid, data_out, phase_err
   );
endinterface

// File: rtl/pw_psum_accumulator_requant_lane.sv
// One lane of requantization: round-half-up, arithmetic right shift,
// optional ReLU and saturation to a signed DATA_WIDTH result. Purely combinational.
module pw_psum_accumulator_requant_lane
   import pw_psum_accumulator_pkg::*;
#(
   parameter int ACC_WIDTH   = 22,
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int SHIFT_WIDTH = SHIFT_WIDTH_DEF
) (
   input  logic signed [ACC_WIDTH-1:0]  sum_i,
   input  logic        [SHIFT_WIDTH-1:0] shift_i,
   input  logic                          relu_en_i,
   output logic signed [DATA_WIDTH-1:0] q_o
);

   // Wide enough that the rounding constant for the largest shift cannot overflow.
   localparam int RW = ACC_WIDTH + (1 << SHIFT_WIDTH);
   localparam logic signed [RW-1:0]      SAT_MAX = RW'(sat_hi(DATA_WIDTH));
   localparam logic signed [RW-1:0]      SAT_MIN = RW'(sat_lo(DATA_WIDTH));
   localparam logic signed [RW-1:0]      R_ONE   = RW'(1);
   localparam logic [SHIFT_WIDTH-1:0]    SH_ONE  = SHIFT_WIDTH'(1);

   function automatic logic signed [RW-1:0] round_shift(
      input logic signed [ACC_WIDTH-1:0] s,
      input logic [SHIFT_WIDTH-1:0]      sh
   );
      logic signed [RW-1:0] r;
      r = RW'(s);
      if (sh != '0) r = r + (R_ONE <<< (sh - SH_ONE));
      return r >>> sh;
   endfunction

   function automatic logic signed [DATA_WIDTH-1:0] saturate(
      input logic signed [RW-1:0] v,
      input logic                 relu
   );
      logic signed [RW-1:0] c;
      c = v;
      if (relu && c[RW-1]) c = '0;
      if (c > SAT_MAX)      c = SAT_MAX;
      else if (c < SAT_MIN) c = SAT_MIN;
      return c[DATA_WIDTH-1:0];
   endfunction

   assign q_o = saturate(round_shift(sum_i, shift_i), relu_en_i);

endmodule

// File: rtl/pw_psum_accumulator.sv
// Pointwise-conv partial-sum combiner: pairs low/high slice psums per pixel,
// adds bias, and requantizes each lane to int8 through a two-stage pipeline.
module pw_psum_accumulator
   import pw_psum_accumulator_pkg::*;
#(
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int PE_NUM      = PE_NUM_DEF,
   parameter int PSUM_WIDTH  = PSUM_WIDTH_DEF,
   parameter int BIAS_WIDTH  = BIAS_WIDTH_DEF,
   parameter int SHIFT_WIDTH = SHIFT_WIDTH_DEF
) (
   input logic                  clk,
   input logic                  rst,
   pw_psum_accumulator_if.slave bus
);

   localparam int ACC_WIDTH = acc_width(PSUM_WIDTH, BIAS_WIDTH);

   state_e state_q, state_d;
   logic signed [PSUM_WIDTH-1:0] acc_q [PE_NUM];
   logic signed [PSUM_WIDTH-1:0] acc_d [PE_NUM];
   logic signed [PSUM_WIDTH-1:0] psum_lane [PE_NUM];
   logic signed [BIAS_WIDTH-1:0] bias_lane [PE_NUM];
   logic                         launch;
   logic                         err_q, err_d;

   logic signed [ACC_WIDTH-1:0]  sum_p1_q [PE_NUM];
   logic signed [ACC_WIDTH-1:0]  sum_p1_d [PE_NUM];
   logic                         vld_p1_q, vld_p1_d;

   logic signed [DATA_WIDTH-1:0] q_lane [PE_NUM];
   logic [PE_NUM*DATA_WIDTH-1:0] data_p2_q, data_p2_d;
   logic                         vld_p2_q, vld_p2_d;

   for (genvar g = 0; g < PE_NUM; g++) begin : g_lane
      assign psum_lane[g] = $signed(bus.psum_in[g*PSUM_WIDTH +: PSUM_WIDTH]);
      assign bias_lane[g] = $signed(bus.bias_in[g*BIAS_WIDTH +: BIAS_WIDTH]);

      pw_psum_accumulator_requant_lane #(
         .ACC_WIDTH   (ACC_WIDTH),
         .DATA_WIDTH  (DATA_WIDTH),
         .SHIFT_WIDTH (SHIFT_WIDTH)
      ) u_requant (
         .sum_i     (sum_p1_q[g]),
         .shift_i   (bus.shift_in),
         .relu_en_i (bus.relu_en),
         .q_o       (q_lane[g])
      );
   end

   // A low slice always (re)loads acc, so a repeated low resyncs on the newest one.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      launch  = 1'b0;
      err_d   = 1'b0;
      if (bus.psum_valid) begin
         if (!bus.psum_phase) begin
            acc_d   = psum_lane;
            state_d = ST_WAIT_HI;
            err_d   = (state_q == ST_WAIT_HI);
         end else if (state_q == ST_WAIT_HI) begin
            launch  = 1'b1;
            state_d = ST_IDLE;
         end else begin
            err_d   = 1'b1;
         end
      end
   end

   // Stage 1: full-precision sum of both halves and bias.
   always_comb begin
      sum_p1_d = sum_p1_q;
      vld_p1_d = launch;
      if (launch) begin
         for (int i = 0; i < PE_NUM; i++) begin
            sum_p1_d[i] = ACC_WIDTH'(acc_q[i]) + ACC_WIDTH'(psum_lane[i])
                        + ACC_WIDTH'(bias_lane[i]);
         end
      end
   end

   // Stage 2: register requantized lanes; data holds between pixels.
   always_comb begin
      data_p2_d = data_p2_q;
      vld_p2_d  = vld_p1_q;
      if (vld_p1_q) begin
         for (int i = 0; i < PE_NUM; i++) begin
            data_p2_d[i*DATA_WIDTH +: DATA_WIDTH] = q_lane[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         err_q     <= 1'b0;
         vld_p1_q  <= 1'b0;
         vld_p2_q  <= 1'b0;
         data_p2_q <= '0;
         for (int i = 0; i < PE_NUM; i++) begin
            acc_q[i]    <= '0;
            sum_p1_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         err_q     <= err_d;
         vld_p1_q  <= vld_p1_d;
         vld_p2_q  <= vld_p2_d;
         data_p2_q <= data_p2_d;
         acc_q     <= acc_d;
         sum_p1_q  <= sum_p1_d;
      end
   end

   assign bus.out_valid = vld_p2_q;
   assign bus.data_out  = data_p2_q;
   assign bus.phase_err = err_q;

endmodule

// File: tb/tb_pw_psum_accumulator.sv
// Scoreboard bench for pw_psum_accumulator: random and directed slice streams
// against a pixel-level arithmetic reference model.
module tb_pw_psum_accumulator;

   localparam int PE = 8;
   localparam int PW = 20;
   localparam int BW = 16;
   localparam int DW = 8;
   localparam int SW = 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pw_psum_accumulator_if #(.DATA_WIDTH(DW), .PE_NUM(PE), .PSUM_WIDTH(PW),
                            .BIAS_WIDTH(BW), .SHIFT_WIDTH(SW)) bus_if ();

   pw_psum_accumulator #(.DATA_WIDTH(DW), .PE_NUM(PE), .PSUM_WIDTH(PW),
                         .BIAS_WIDTH(BW), .SHIFT_WIDTH(SW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [PE*DW-1:0] data;
      int               due;
   } exp_t;

   exp_t   exp_q[$];
   int     err_q[$];
   exp_t   mon_e;
   int     mon_d;
   bit     pend;
   longint lo_v [PE];
   int     cur_shift;
   bit     cur_relu;

   // Pixel-level reference: round half up, floor division by 2^shift, ReLU, clamp.
   function automatic longint ref_q(input longint sum, input int sh, input bit relu);
      longint r, d, q, hi, lo;
      hi = (longint'(1) <<< (DW - 1)) - 1;
      lo = -(longint'(1) <<< (DW - 1));
      r  = sum + ((sh > 0) ? (longint'(1) <<< (sh - 1)) : 0);
      d  = longint'(1) <<< sh;
      if (r >= 0) q = r / d;
      else        q = -((-r + d - 1) / d);
      if (relu && q < 0) q = 0;
      if (q > hi) q = hi;
      if (q < lo) q = lo;
      return q;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_cfg(input int sh, input bit relu);
      cur_shift       = sh;
      cur_relu        = relu;
      bus_if.shift_in = SW'(sh);
      bus_if.relu_en  = relu;
   endtask

   task automatic drive(input bit v, input bit ph,
                        input logic [PE*PW-1:0] p, input logic [PE*BW-1:0] b);
      longint s, q;
      logic [PE*DW-1:0] e;
      @(posedge clk);
      #1;
      bus_if.psum_valid = v;
      bus_if.psum_phase = ph;
      bus_if.psum_in    = p;
      bus_if.bias_in    = b;
      if (v) begin
         if (!ph) begin
            if (pend) err_q.push_back(cyc + 1);
            pend = 1'b1;
            for (int i = 0; i < PE; i++) lo_v[i] = $signed(p[i*PW +: PW]);
         end else if (!pend) begin
            err_q.push_back(cyc + 1);
         end else begin
            e = '0;
            for (int i = 0; i < PE; i++) begin
               s = lo_v[i] + longint'($signed(p[i*PW +: PW])) + longint'($signed(b[i*BW +: BW]));
               q = ref_q(s, cur_shift, cur_relu);
               e[i*DW +: DW] = q[DW-1:0];
            end
            exp_q.push_back('{data: e, due: cyc + 2});
            pend = 1'b0;
         end
      end
   endtask

   function automatic logic [PE*PW-1:0] rnd_psum();
      logic [PE*PW-1:0] p;
      for (int i = 0; i < PE; i++) p[i*PW +: PW] = PW'($urandom);
      return p;
   endfunction

   function automatic logic [PE*BW-1:0] rnd_bias();
      logic [PE*BW-1:0] b;
      for (int i = 0; i < PE; i++) b[i*BW +: BW] = BW'($urandom);
      return b;
   endfunction

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'($urandom), rnd_psum(), rnd_bias());
   endtask

   task automatic slice_l0(input bit ph, input int v, input int bias);
      logic [PE*PW-1:0] p;
      logic [PE*BW-1:0] b;
      p = rnd_psum();
      b = rnd_bias();
      p[PW-1:0] = PW'(v);
      b[BW-1:0] = BW'(bias);
      drive(1'b1, ph, p, b);
   endtask

   task automatic pix_l0(input int lo, input int hi, input int bias);
      slice_l0(1'b0, lo, 0);
      slice_l0(1'b1, hi, bias);
   endtask

   task automatic lane0_is(input string name, input int exp);
      logic [DW-1:0] e;
      e = DW'(exp);
      check(name, 64'(bus_if.data_out[DW-1:0]), 64'(e));
   endtask

   // Monitor: every output pulse must match the head of its queue, on time.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (bus_if.out_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out_valid: got data %h expected none", bus_if.data_out);
            end else begin
               mon_e = exp_q.pop_front();
               check("data_out", 64'(bus_if.data_out), 64'(mon_e.data));
               check("out_latency", 64'(cyc), 64'(mon_e.due));
            end
         end
         if (bus_if.phase_err) begin
            if (err_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_phase_err: got pulse at cycle %0d expected none", cyc);
            end else begin
               mon_d = err_q.pop_front();
               check("phase_err_time", 64'(cyc), 64'(mon_d));
            end
         end
      end
   end

   initial begin
      rst               = 1'b1;
      bus_if.psum_valid = 1'b0;
      bus_if.psum_phase = 1'b0;
      bus_if.psum_in    = '0;
      bus_if.bias_in    = '0;
      pend              = 1'b0;
      set_cfg(2, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(bus_if.out_valid), 64'(0));
      check("rst_data_out", 64'(bus_if.data_out), 64'(0));
      check("rst_phase_err", 64'(bus_if.phase_err), 64'(0));
      rst = 1'b0;

      // Basic pixel
      pix_l0(100, 50, 10);
      idle(3);
      lane0_is("basic_lane0", 40);

      // Saturation and ReLU
      set_cfg(0, 1'b0);
      pix_l0(5000, 5000, 0);
      idle(3);
      lane0_is("sat_pos", 127);
      pix_l0(-5000, -5000, 0);
      idle(3);
      lane0_is("sat_neg", -128);
      set_cfg(0, 1'b1);
      pix_l0(-5000, -5000, 0);
      idle(3);
      lane0_is("relu_neg", 0);

      // Negative rounding
      set_cfg(2, 1'b0);
      pix_l0(-6, 0, 0);
      idle(3);
      lane0_is("round_m6_s2", -1);
      set_cfg(1, 1'b0);
      pix_l0(-5, 0, 0);
      idle(3);
      lane0_is("round_m5_s1", -2);

      // Ordering: orphan high, then low A, low B, high C
      slice_l0(1'b1, 77, 3);
      idle(3);
      slice_l0(1'b0, 1000, 0);
      slice_l0(1'b0, 20, 0);
      slice_l0(1'b1, 30, 4);
      idle(3);
      lane0_is("resync_b_plus_c", 27);

      // Back-to-back, then with bubbles
      set_cfg($urandom_range(0, 8), 1'($urandom));
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 1'b0, rnd_psum(), rnd_bias());
         drive(1'b1, 1'b1, rnd_psum(), rnd_bias());
      end
      idle(3);
      set_cfg($urandom_range(0, 8), 1'($urandom));
      for (int k = 0; k < 4; k++) begin
         idle($urandom_range(0, 2));
         drive(1'b1, 1'b0, rnd_psum(), rnd_bias());
         idle($urandom_range(0, 2));
         drive(1'b1, 1'b1, rnd_psum(), rnd_bias());
      end
      idle(3);

      // Random phase streams, including out-of-order slices
      for (int blk = 0; blk < 6; blk++) begin
         set_cfg($urandom_range(0, 12), 1'($urandom));
         for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            else drive(1'b1, ($urandom_range(0, 4) == 0) ? pend : !pend, rnd_psum(), rnd_bias());
         end
         if (pend) drive(1'b1, 1'b1, rnd_psum(), rnd_bias());
         idle(3);
      end

      // Reset while waiting for the high slice
      set_cfg(2, 1'b0);
      pix_l0(100, 50, 10);
      idle(3);
      lane0_is("pre_reset_lane0", 40);
      slice_l0(1'b0, 123, 0);
      idle(1);
      #2;
      rst  = 1'b1;
      pend = 1'b0;
      exp_q.delete();
      err_q.delete();
      #1;
      check("mid_rst_out_valid", 64'(bus_if.out_valid), 64'(0));
      check("mid_rst_data_out", 64'(bus_if.data_out), 64'(0));
      check("mid_rst_phase_err", 64'(bus_if.phase_err), 64'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      slice_l0(1'b1, 55, 1);
      idle(2);
      pix_l0(-100, 20, -4);
      idle(3);
      lane0_is("post_reset_lane0", -21);

      idle(5);
      check("exp_queue_drained", 64'(exp_q.size()), 64'(0));
      check("err_queue_drained", 64'(err_q.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
